// File: rtl/disp_sched.sv
// disp_sched: round-robin owner of a 4-digit 7-segment display shared by three requesters.
// Optional macro DISP_BLINK_EN blinks the display while requester 2 holds it.
module disp_sched #(
    parameter int HOLD_TICKS  = 100_000_000,
    parameter int BLINK_TICKS = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    output logic [2:0]  gnt,
    output logic        busy,
    output logic [6:0]  d1,
    output logic [6:0]  d2,
    output logic [6:0]  d3,
    output logic [6:0]  d4
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [26:0] HOLD_LAST = 27'(HOLD_TICKS - 1);

    state_t      state;
    logic [26:0] cnt;
    logic [1:0]  lp;
    logic [1:0]  c1;
    logic [1:0]  c2;
    logic [1:0]  nxt;
    logic        has_nxt;
    logic        release_ev;
    logic        grant_ev;
    logic [15:0] shown;
    logic        visible;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Search order starts just after the last owner, so the owner itself comes last.
    always_comb begin
        c1      = (lp == 2'd2) ? 2'd0 : lp + 2'd1;
        c2      = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        has_nxt = 1'b1;
        nxt     = lp;
        if (req[c1])      nxt = c1;
        else if (req[c2]) nxt = c2;
        else if (req[lp]) nxt = lp;
        else              has_nxt = 1'b0;
    end

    always_comb begin
        release_ev = (state == HOLD) && (!req[lp] || (cnt == HOLD_LAST));
        grant_ev   = has_nxt && ((state == IDLE) || release_ev);
        case (gnt)
            3'b001:  shown = val0;
            3'b010:  shown = val1;
            3'b100:  shown = val2;
            default: shown = 16'h0000;
        endcase
    end

    assign busy = |gnt;

`ifdef DISP_BLINK_EN
    localparam logic [26:0] BLINK_LAST = 27'(BLINK_TICKS - 1);

    logic [26:0] bcnt;
    logic        blank_ph;

    // Blink phase restarts visible on every grant to requester 2, including re-grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt     <= '0;
            blank_ph <= 1'b0;
        end else if (grant_ev && (nxt == 2'd2)) begin
            bcnt     <= '0;
            blank_ph <= 1'b0;
        end else if (gnt == 3'b100) begin
            if (bcnt == BLINK_LAST) begin
                bcnt     <= '0;
                blank_ph <= !blank_ph;
            end else begin
                bcnt <= bcnt + 27'd1;
            end
        end
    end

    assign visible = !blank_ph;
`else
    assign visible = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 3'b000;
            cnt   <= '0;
            lp    <= 2'd2;
            d1    <= 7'h7F;
            d2    <= 7'h7F;
            d3    <= 7'h7F;
            d4    <= 7'h7F;
        end else begin
            if ((gnt == 3'b000) || !visible) begin
                d1 <= 7'h7F;
                d2 <= 7'h7F;
                d3 <= 7'h7F;
                d4 <= 7'h7F;
            end else begin
                d1 <= hex7(shown[3:0]);
                d2 <= hex7(shown[7:4]);
                d3 <= hex7(shown[11:8]);
                d4 <= hex7(shown[15:12]);
            end

            if (grant_ev) begin
                state <= HOLD;
                gnt   <= 3'b001 << nxt;
                cnt   <= '0;
                lp    <= nxt;
            end else if (release_ev) begin
                state <= IDLE;
                gnt   <= 3'b000;
                cnt   <= '0;
            end else if (state == HOLD) begin
                cnt <= cnt + 27'd1;
            end
        end
    end

endmodule
